// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signal bundle of the burst arbiter.
// master = arbiter side, slave = caches plus memory port.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  i_i_req;
    logic [ADDR_WIDTH-1:0] i_i_addr;
    logic                  o_i_gnt;
    logic                  o_i_rvalid;
    logic [DATA_WIDTH-1:0] o_i_rdata;
    logic                  o_i_done;

    logic                  i_d_req;
    logic                  i_d_we;
    logic [ADDR_WIDTH-1:0] i_d_addr;
    logic [DATA_WIDTH-1:0] i_d_wdata;
    logic                  o_d_wnext;
    logic                  o_d_gnt;
    logic                  o_d_rvalid;
    logic [DATA_WIDTH-1:0] o_d_rdata;
    logic                  o_d_done;

    logic                  o_mem_req;
    logic                  o_mem_we;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic                  i_mem_ack;
    logic                  o_mem_wvalid;
    logic [DATA_WIDTH-1:0] o_mem_wdata;
    logic                  i_mem_wready;
    logic                  i_mem_rvalid;
    logic [DATA_WIDTH-1:0] i_mem_rdata;

    modport master (
        input  i_i_req, i_i_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata,
               i_mem_ack, i_mem_wready, i_mem_rvalid, i_mem_rdata,
        output o_i_gnt, o_i_rvalid, o_i_rdata, o_i_done,
               o_d_gnt, o_d_rvalid, o_d_rdata, o_d_done, o_d_wnext,
               o_mem_req, o_mem_we, o_mem_addr, o_mem_wvalid, o_mem_wdata
    );

    modport slave (
        output i_i_req, i_i_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata,
               i_mem_ack, i_mem_wready, i_mem_rvalid, i_mem_rdata,
        input  o_i_gnt, o_i_rvalid, o_i_rdata, o_i_done,
               o_d_gnt, o_d_rvalid, o_d_rdata, o_d_done, o_d_wnext,
               o_mem_req, o_mem_we, o_mem_addr, o_mem_wvalid, o_mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin I/D burst arbiter onto one memory port, one burst in flight.
// Latency: request -> gnt + mem_req next cycle; last beat -> done next cycle.
// Backpressure: mem_req held until ack; beats advance only on rvalid / wready.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BEATS      = 8
) (
    input  logic          i_clk,
    input  logic          i_arstn,
    mem_arbiter_if.master bus
);
    localparam int CW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFS = $clog2(BEATS * DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFFS;
    localparam logic [CW-1:0]         LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t                state;
    logic                  owner;
    logic                  last_owner;
    logic                  we_q;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  i_gnt_q, d_gnt_q;
    logic                  i_done_q, d_done_q;
    logic                  mem_req_q;

    logic win_vld, win_d;
    logic rd_beat, wr_vld, wr_beat, beat;
    logic i_rv, d_rv;

    // On a tie the requester that did not win last time takes the bus.
    always_comb begin
        win_vld = bus.i_i_req | bus.i_d_req;
        win_d   = bus.i_d_req;
        if (bus.i_i_req && bus.i_d_req) begin
            win_d = ~last_owner;
        end
    end

    assign rd_beat = (state == DATA) && !we_q && bus.i_mem_rvalid;
    assign wr_vld  = (state == DATA) && we_q;
    assign wr_beat = wr_vld && bus.i_mem_wready;
    assign beat    = rd_beat | wr_beat;
    assign i_rv    = rd_beat && !owner;
    assign d_rv    = rd_beat && owner;

    always_ff @(posedge i_clk) begin
        if (!i_arstn) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            we_q       <= 1'b0;
            cnt        <= '0;
            addr_q     <= '0;
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            mem_req_q  <= 1'b0;
        end else begin
            i_gnt_q  <= 1'b0;
            d_gnt_q  <= 1'b0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        owner      <= win_d;
                        last_owner <= win_d;
                        we_q       <= win_d & bus.i_d_we;
                        addr_q     <= (win_d ? bus.i_d_addr : bus.i_i_addr) & ADDR_MASK;
                        i_gnt_q    <= ~win_d;
                        d_gnt_q    <= win_d;
                        mem_req_q  <= 1'b1;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.i_mem_ack) begin
                        mem_req_q <= 1'b0;
                        cnt       <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST_BEAT) begin
                            i_done_q <= ~owner;
                            d_done_q <= owner;
                            state    <= DONE;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_i_gnt      = i_gnt_q;
    assign bus.o_d_gnt      = d_gnt_q;
    assign bus.o_i_done     = i_done_q;
    assign bus.o_d_done     = d_done_q;
    assign bus.o_mem_req    = mem_req_q;
    assign bus.o_mem_we     = we_q;
    assign bus.o_mem_addr   = addr_q;

    // Data paths are gated so idle and reset states present all-zero outputs.
    assign bus.o_i_rvalid   = i_rv;
    assign bus.o_i_rdata    = i_rv ? bus.i_mem_rdata : '0;
    assign bus.o_d_rvalid   = d_rv;
    assign bus.o_d_rdata    = d_rv ? bus.i_mem_rdata : '0;
    assign bus.o_mem_wvalid = wr_vld;
    assign bus.o_mem_wdata  = wr_vld ? bus.i_d_wdata : '0;
    assign bus.o_d_wnext    = wr_beat;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: arbitration vector table plus burst corner sequences,
// read/write beats checked against a queue scoreboard.
module tb_mem_arbiter;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int BEATS = 8;

    logic clk;
    logic arstn;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(BEATS)) dut (
        .i_clk   (clk),
        .i_arstn (arstn),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          owner;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        logic          ireq;
        logic          dreq;
        logic          dwe;
        logic [AW-1:0] iaddr;
        logic [AW-1:0] daddr;
        logic          exp_i;
        logic          exp_d;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
    } vec_t;

    beat_t         rq[$];
    logic [DW-1:0] wq[$];
    vec_t          vecs[8];

    int  tests = 0;
    int  fails = 0;
    bit  mon_en = 0;
    int  i_gnt_cnt = 0, d_gnt_cnt = 0, i_done_cnt = 0, d_done_cnt = 0, wnext_cnt = 0;
    int  exp_i_gnt = 0, exp_d_gnt = 0, exp_i_done = 0, exp_d_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard whenever the DUT produces a beat.
    always @(negedge clk) begin : mon
        beat_t e;
        if (mon_en) begin
            if (bus.o_i_gnt)  i_gnt_cnt++;
            if (bus.o_d_gnt)  d_gnt_cnt++;
            if (bus.o_i_done) i_done_cnt++;
            if (bus.o_d_done) d_done_cnt++;
            if (bus.o_d_wnext) wnext_cnt++;
            if (bus.o_i_rvalid || bus.o_d_rvalid) begin
                chk("rvalid_both", bus.o_i_rvalid & bus.o_d_rvalid, 0);
                if (rq.size() == 0) begin
                    chk("rvalid_unexpected", {bus.o_i_rvalid, bus.o_d_rvalid}, 0);
                end else begin
                    e = rq.pop_front();
                    chk("rvalid_owner", bus.o_d_rvalid, e.owner);
                    chk("rdata", bus.o_d_rvalid ? bus.o_d_rdata : bus.o_i_rdata, e.data);
                end
            end
            if (bus.o_mem_wvalid) chk("mem_wdata_track", bus.o_mem_wdata, bus.i_d_wdata);
            if (bus.o_mem_wvalid && bus.i_mem_wready) begin
                chk("d_wnext", bus.o_d_wnext, 1);
                if (wq.size() == 0) chk("wbeat_unexpected", bus.o_mem_wvalid, 0);
                else chk("wdata", bus.o_mem_wdata, wq.pop_front());
            end else begin
                chk("d_wnext_idle", bus.o_d_wnext, 0);
            end
        end
    end

    task automatic do_reset();
        bus.i_i_req = 0; bus.i_i_addr = '0; bus.i_d_req = 0; bus.i_d_we = 0;
        bus.i_d_addr = '0; bus.i_d_wdata = '0; bus.i_mem_ack = 0;
        bus.i_mem_wready = 0; bus.i_mem_rvalid = 0; bus.i_mem_rdata = '0;
        arstn = 0;
        cyc();
        cyc();
        arstn = 1;
    endtask

    // Entered at the first cycle after the gnt cycle; returns at the start of
    // the first IDLE cycle after done.
    task automatic run_burst(input logic own, input logic we, input int ack_wait,
                             input bit stall, input int pulse_at);
        int b;
        int c;
        beat_t e;
        if (own) begin exp_d_gnt++; exp_d_done++; end
        else begin exp_i_gnt++; exp_i_done++; end
        for (int k = 0; k < ack_wait; k++) begin
            bus.i_mem_ack    = 0;
            bus.i_mem_rvalid = 1;
            bus.i_mem_rdata  = 64'hDEAD_0000_0000_0000 + 64'(k);
            @(negedge clk);
            chk("mem_req_hold", bus.o_mem_req, 1);
            cyc();
        end
        bus.i_mem_rvalid = 0;
        bus.i_mem_ack    = 1;
        @(negedge clk);
        chk("mem_req_at_ack", bus.o_mem_req, 1);
        cyc();
        bus.i_mem_ack = 0;
        b = 0;
        c = 0;
        while (b < BEATS && c < 100) begin
            if (pulse_at >= 0) bus.i_d_req = (b == pulse_at);
            if (we) begin
                bus.i_d_wdata    = {$urandom, $urandom};
                bus.i_mem_wready = stall ? (c % 2 == 0) : 1'b1;
                if (bus.i_mem_wready) begin
                    wq.push_back(bus.i_d_wdata);
                    b++;
                end
            end else begin
                bus.i_mem_rdata  = {$urandom, $urandom};
                bus.i_mem_rvalid = 1;
                e.owner = own;
                e.data  = bus.i_mem_rdata;
                rq.push_back(e);
                b++;
            end
            c++;
            cyc();
        end
        bus.i_mem_rvalid = 0;
        bus.i_mem_wready = 0;
        if (pulse_at >= 0) bus.i_d_req = 0;
        @(negedge clk);
        chk("done_i", bus.o_i_done, !own);
        chk("done_d", bus.o_d_done, own);
        chk("mem_req_after_burst", bus.o_mem_req, 0);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1, 0, 0, 64'h1038, 64'h0, 1, 0, 0, 64'h1000};
        vecs[1] = '{1, 1, 0, 64'h9999, 64'h2345, 0, 1, 0, 64'h2340};
        vecs[2] = '{1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7000, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFC0};
        vecs[3] = '{0, 1, 1, 64'h0, 64'h8000_007F, 0, 1, 1, 64'h8000_0040};
        vecs[4] = '{1, 1, 1, 64'h3F, 64'h40, 1, 0, 0, 64'h0};
        vecs[5] = '{1, 1, 1, 64'h100, 64'h123, 0, 1, 1, 64'h100};
        vecs[6] = '{0, 0, 1, 64'h5000, 64'h6000, 0, 0, 0, 64'h0};
        vecs[7] = '{1, 1, 0, 64'hABCD, 64'h1, 1, 0, 0, 64'hABC0};

        // Reset state
        do_reset();
        mon_en = 1;
        @(negedge clk);
        chk("rst_regs", {bus.o_i_gnt, bus.o_d_gnt, bus.o_mem_req, bus.o_mem_we,
                         bus.o_i_done, bus.o_d_done}, 0);
        chk("rst_addr", bus.o_mem_addr, 0);
        cyc();

        // Tie from reset: I first, then D, then re-asserted I only after D's done
        bus.i_i_req = 1; bus.i_i_addr = 64'h1038;
        bus.i_d_req = 1; bus.i_d_addr = 64'h2010; bus.i_d_we = 1;
        cyc();
        bus.i_i_req = 0;
        @(negedge clk);
        chk("tie_gnt_i", bus.o_i_gnt, 1);
        chk("tie_gnt_d", bus.o_d_gnt, 0);
        chk("tie_req", bus.o_mem_req, 1);
        chk("tie_addr", bus.o_mem_addr, 64'h1000);
        cyc();
        run_burst(0, 0, 0, 0, -1);
        bus.i_i_req = 1;
        cyc();
        @(negedge clk);
        chk("rr_gnt_d", bus.o_d_gnt, 1);
        chk("rr_gnt_i", bus.o_i_gnt, 0);
        chk("rr_we", bus.o_mem_we, 1);
        chk("rr_addr", bus.o_mem_addr, 64'h2000);
        bus.i_d_req = 0;
        cyc();
        run_burst(1, 1, 0, 0, -1);
        cyc();
        @(negedge clk);
        chk("rr_gnt_i_after_d", bus.o_i_gnt, 1);
        bus.i_i_req = 0;
        cyc();
        run_burst(0, 0, 0, 0, -1);
        chk("rr_i_gnt_cnt", i_gnt_cnt, 2);
        chk("rr_d_gnt_cnt", d_gnt_cnt, 1);

        // Arbitration vectors from a fresh reset
        do_reset();
        cyc();
        foreach (vecs[n]) begin
            bus.i_i_req  = vecs[n].ireq;  bus.i_i_addr = vecs[n].iaddr;
            bus.i_d_req  = vecs[n].dreq;  bus.i_d_addr = vecs[n].daddr;
            bus.i_d_we   = vecs[n].dwe;
            cyc();
            bus.i_i_req = 0;
            bus.i_d_req = 0;
            @(negedge clk);
            chk($sformatf("vec%0d_gnt_i", n), bus.o_i_gnt, vecs[n].exp_i);
            chk($sformatf("vec%0d_gnt_d", n), bus.o_d_gnt, vecs[n].exp_d);
            chk($sformatf("vec%0d_req", n), bus.o_mem_req, vecs[n].exp_i | vecs[n].exp_d);
            if (vecs[n].exp_i | vecs[n].exp_d) begin
                chk($sformatf("vec%0d_addr", n), bus.o_mem_addr, vecs[n].exp_addr);
                chk($sformatf("vec%0d_we", n), bus.o_mem_we, vecs[n].exp_we);
                cyc();
                run_burst(vecs[n].exp_d, vecs[n].exp_we, 0, 0, -1);
            end else begin
                cyc();
            end
        end

        // D writeback with wready toggling 1,0,1,...
        begin
            int w0;
            w0 = wnext_cnt;
            bus.i_d_req = 1; bus.i_d_we = 1; bus.i_d_addr = 64'h3008;
            cyc();
            bus.i_d_req = 0;
            @(negedge clk);
            chk("wb_gnt_d", bus.o_d_gnt, 1);
            chk("wb_addr", bus.o_mem_addr, 64'h3000);
            cyc();
            run_burst(1, 1, 0, 1, -1);
            chk("wb_wnext_count", wnext_cnt - w0, BEATS);
        end

        // Ack withheld 5 cycles with spurious rvalid in ADDR
        bus.i_i_req = 1; bus.i_i_addr = 64'h4040;
        cyc();
        bus.i_i_req = 0;
        @(negedge clk);
        chk("ackw_gnt_i", bus.o_i_gnt, 1);
        cyc();
        run_burst(0, 0, 5, 0, -1);

        // D request pulsed for one cycle during an I burst is never granted
        bus.i_i_req = 1; bus.i_i_addr = 64'h5000;
        cyc();
        bus.i_i_req = 0;
        bus.i_d_we = 0; bus.i_d_addr = 64'h7700;
        cyc();
        run_burst(0, 0, 0, 0, 2);
        cyc();
        cyc();
        @(negedge clk);
        chk("wd_idle_req", bus.o_mem_req, 0);
        chk("wd_d_gnt", bus.o_d_gnt, 0);
        cyc();

        // Reset after the third beat of an I read
        bus.i_i_req = 1; bus.i_i_addr = 64'h5500;
        cyc();
        bus.i_i_req = 0;
        @(negedge clk);
        chk("rmb_gnt_i", bus.o_i_gnt, 1);
        exp_i_gnt++;
        cyc();
        bus.i_mem_ack = 1;
        cyc();
        bus.i_mem_ack = 0;
        for (int k = 0; k < 3; k++) begin
            beat_t e;
            bus.i_mem_rdata  = {$urandom, $urandom};
            bus.i_mem_rvalid = 1;
            e.owner = 0;
            e.data  = bus.i_mem_rdata;
            rq.push_back(e);
            cyc();
        end
        bus.i_mem_rvalid = 0;
        arstn = 0;
        cyc();
        arstn = 1;
        bus.i_mem_rvalid = 1; bus.i_mem_ack = 1; bus.i_mem_wready = 1;
        bus.i_mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        chk("rmb_outputs", {bus.o_i_gnt, bus.o_d_gnt, bus.o_mem_req, bus.o_mem_we,
                            bus.o_i_done, bus.o_d_done, bus.o_i_rvalid, bus.o_d_rvalid,
                            bus.o_mem_wvalid, bus.o_d_wnext}, 0);
        chk("rmb_addr", bus.o_mem_addr, 0);
        chk("rmb_rdata", bus.o_i_rdata, 0);
        cyc();
        bus.i_mem_rvalid = 0; bus.i_mem_ack = 0; bus.i_mem_wready = 0;
        cyc();
        cyc();
        bus.i_i_req = 1; bus.i_i_addr = 64'h6008;
        cyc();
        bus.i_i_req = 0;
        @(negedge clk);
        chk("rmb_regnt_i", bus.o_i_gnt, 1);
        chk("rmb_regnt_addr", bus.o_mem_addr, 64'h6000);
        cyc();
        run_burst(0, 0, 0, 0, -1);
        cyc();

        chk("rq_empty", rq.size(), 0);
        chk("wq_empty", wq.size(), 0);
        chk("i_gnt_total", i_gnt_cnt, exp_i_gnt);
        chk("d_gnt_total", d_gnt_cnt, exp_d_gnt);
        chk("i_done_total", i_done_cnt, exp_i_done);
        chk("d_done_total", d_done_cnt, exp_d_done);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
